spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
- Downstream consumer of the Wishbone-side interface's 41-bit command word {ADR[7:0], DAT[31:0], WE}.
- Serialises each command onto a mode-0 SPI bus (CPOL=0, CPHA=0).
- Returns a 41-bit response word using the same layout; read data sits in [39:8].
- Uses a 4-phase request/acknowledge handshake (BUF_STATUS / BUF_ACK) on the buffer side.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 1..255; 0 is illegal.
- CS_SETUP, 2: clocks with CS_N low before the first SCLK rise; 0 is legal.
- CS_HOLD, 2: clocks after the last SCLK fall before CS_N is released; 0 is legal.

Ports:
- WB_CLK_I  in  1  system clock; the only clock, all logic on its rising edge.
- WB_RST_I  in  1  reset, synchronous, active-low.
- BUF_STATUS  in  1  command request level from the buffer side.
- BUF_DATA_I  in  41  command {ADR[40:33], DAT[32:1], WE[0]}.
- BUF_ACK  out  1  response valid / command done.
- BUF_DATA_O  out  41  response {ADR, RDATA or echoed DAT, WE}.
- BUSY  out  1  high from command latch until return to IDLE.
- SPI_SCLK  out  1  serial clock, idles low.
- SPI_MOSI  out  1  serial data out, MSB first.
- SPI_MISO  in  1  serial data in.
- SPI_CS_N  out  1  chip select, active-low.

Behaviour:
- Reset (WB_RST_I=0 at a clock edge):
  - BUF_ACK=0, BUF_DATA_O=0, BUSY=0, SPI_SCLK=0, SPI_MOSI=0, SPI_CS_N=1; state=IDLE; all counters 0.
  - Reset applies mid-frame too: the bus is released on the same edge and the command is dropped with no ACK.
- Frame: 41 bits, MSB first, order {WE, ADR[7:0], DAT[31:0]}.
  - Reads (WE=0) send DAT as zeros.
  - MISO bits 0..8 are ignored; bits 9..40 form RDATA[31:0], MSB first.
- IDLE:
  - BUF_STATUS=1 and BUF_ACK=0 -> latch BUF_DATA_I, set BUSY=1, set CS_N=0, drive MOSI with the first bit (WE), go to SETUP.
- SETUP: wait CS_SETUP clocks, then go to SHIFT.
- SHIFT:
  - A divider generates alternating half-periods of CLK_DIV clocks; SCLK starts low.
  - At the end of each low half-period, SCLK rises and MISO is sampled on that same clock edge.
  - At the end of each high half-period, SCLK falls and MOSI advances to the next bit.
  - A bit counter counts from 40 down to 0. After the 41st fall (2*41*CLK_DIV clocks), go to HOLD with SCLK=0 and MOSI=0.
- HOLD: wait CS_HOLD clocks, set CS_N=1, go to ACK.
- ACK:
  - BUF_ACK=1. BUF_DATA_O = {ADR, RDATA, 0} for a read, or {ADR, DAT, 1} for a write (echo).
  - Stay in ACK while BUF_STATUS=1. When BUF_STATUS=0 -> BUF_ACK=0, BUSY=0, go to IDLE.
- Latency: BUF_ACK rises exactly CS_SETUP + 82*CLK_DIV + CS_HOLD + 1 clocks after the edge that latches the request.
- BUF_STATUS dropping mid-frame is ignored: the frame completes, BUF_ACK is high for one clock, then the block returns to IDLE.
- A new request is accepted only after BUF_ACK=0. No back-to-back commands without BUF_STATUS going low for at least one clock.
- BUF_DATA_I is sampled only at the latch edge; later changes have no effect.
- BUF_DATA_O holds its value until the next command's ACK; it is cleared only by reset.

Decomposition:
- Package spi_cmd_pkg:
  - state encoding IDLE/SETUP/SHIFT/HOLD/ACK;
  - FRAME_W=41; field indices ADR_HI=40, ADR_LO=33, DAT_HI=32, DAT_LO=1, WE_BIT=0;
  - RDATA_SKIP=9.
- Sub-module spi_sclk_gen:
  - CLK_DIV counter with an enable input;
  - outputs rise_stb, fall_stb and the SCLK level;
  - synchronous active-low reset.

Test Plan:
- Write: CLK_DIV=4, BUF_DATA_I={8'h12, 32'hDEADBEEF, 1'b1}, BUF_STATUS=1 -> MOSI stream 1,0x12,0xDEADBEEF. BUF_ACK rises 333 clocks after the latch edge with BUF_DATA_O=BUF_DATA_I. CS_N is low for the whole frame.
- Read: BUF_DATA_I={8'hA5, 32'h0, 1'b0}, SPI model drives 9 don't-care bits then 0xCAFEF00D -> MOSI sends 0, 0xA5, then 32 zeros. BUF_DATA_O={8'hA5, 32'hCAFEF00D, 1'b0}.
- Handshake: hold BUF_STATUS=1 for 50 clocks after ACK -> BUF_ACK stays high, no second frame, CS_N stays 1. Drop BUF_STATUS -> BUF_ACK=0 on the next edge.
- Reset at bit 20 of a frame: WB_RST_I=0 for one edge -> CS_N=1, SCLK=0, MOSI=0, BUSY=0, BUF_ACK never rises. The next command runs normally.
- CLK_DIV=1, CS_SETUP=0, CS_HOLD=0 -> SCLK toggles every clock, 41 rises counted, ACK rises 83 clocks after the latch.
- BUF_STATUS dropped after 10 clocks -> full frame is still sent, BUF_ACK is a one-clock pulse, block returns to IDLE.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_master shared definitions
// frame layout, field indices and FSM states
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    ACK
  } state_t;

  localparam int FRAME_W    = 41;
  localparam int ADR_HI     = 40;
  localparam int ADR_LO     = 33;
  localparam int DAT_HI     = 32;
  localparam int DAT_LO     = 1;
  localparam int WE_BIT     = 0;
  localparam int RDATA_SKIP = 9;
  localparam int RDATA_W    = DAT_HI - DAT_LO + 1;

  // wire order is {WE, ADR, DAT}; reads send DAT as zeros
  function automatic logic [FRAME_W-1:0] tx_frame(
    input logic [FRAME_W-1:0] cmd
  );
    logic [RDATA_W-1:0] d;
    d = cmd[WE_BIT] ? cmd[DAT_HI:DAT_LO] : '0;
    return {cmd[WE_BIT], cmd[ADR_HI:ADR_LO], d};
  endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// spi_cmd_master buffer-side handshake
// 4-phase BUF_STATUS / BUF_ACK bundle
interface spi_cmd_master_if;
  import spi_cmd_pkg::*;

  logic               BUF_STATUS;
  logic [FRAME_W-1:0] BUF_DATA_I;
  logic               BUF_ACK;
  logic [FRAME_W-1:0] BUF_DATA_O;
  logic               BUSY;

  modport master (
    output BUF_STATUS,
    output BUF_DATA_I,
    input  BUF_ACK,
    input  BUF_DATA_O,
    input  BUSY
  );

  modport slave (
    input  BUF_STATUS,
    input  BUF_DATA_I,
    output BUF_ACK,
    output BUF_DATA_O,
    output BUSY
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider for spi_cmd_master
// strobes fire in the cycle before SCLK toggles
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic WB_CLK_I,
  input  logic WB_RST_I,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);

  logic [7:0] cnt_q;
  logic       wrap;

  assign wrap     = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise_stb = wrap && !sclk;
  assign fall_stb = wrap && sclk;

  // half-period counter; disabled means parked low and cleared
  always_ff @(posedge WB_CLK_I) begin
    if (!WB_RST_I) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: 41-bit command to mode-0 SPI
// frame {WE, ADR, DAT}, response {ADR, DATA, WE}
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic             WB_CLK_I,
  input  logic             WB_RST_I,
  spi_cmd_master_if.slave  bus,
  output logic             SPI_SCLK,
  output logic             SPI_MOSI,
  input  logic             SPI_MISO,
  output logic             SPI_CS_N
);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [5:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] cmd_q, cmd_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [RDATA_W-1:0] rx_q, rx_d;
  logic [FRAME_W-1:0] dout_q, dout_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               rise_stb, fall_stb;
  logic               sclk_en;

  assign sclk_en        = (state_q == SHIFT);
  assign SPI_MOSI       = mosi_q;
  assign SPI_CS_N       = cs_n_q;
  assign bus.BUF_ACK    = ack_q;
  assign bus.BUF_DATA_O = dout_q;
  assign bus.BUSY       = busy_q;

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .WB_CLK_I(WB_CLK_I),
    .WB_RST_I(WB_RST_I),
    .en      (sclk_en),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .sclk    (SPI_SCLK)
  );

  // next-state and datapath updates for the command sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.BUF_STATUS && !ack_q) begin
          cmd_d   = bus.BUF_DATA_I;
          tx_d    = tx_frame(bus.BUF_DATA_I);
          mosi_d  = bus.BUF_DATA_I[WE_BIT];
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          bit_d   = 6'(FRAME_W - 1);
          cnt_d   = 8'd1;
          state_d = (CS_SETUP == 0) ? SHIFT : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 8'(CS_SETUP)) state_d = SHIFT;
        else                        cnt_d = cnt_q + 8'd1;
      end
      SHIFT: begin
        // the first RDATA_SKIP MISO bits fall out of rx naturally
        // but gating keeps the intent explicit
        if (rise_stb &&
            bit_q <= 6'(FRAME_W - 1 - RDATA_SKIP))
          rx_d = {rx_q[RDATA_W-2:0], SPI_MISO};
        if (fall_stb) begin
          if (bit_q == 6'd0) begin
            mosi_d  = 1'b0;
            cnt_d   = 8'd0;
            state_d = HOLD;
          end else begin
            bit_d  = bit_q - 6'd1;
            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
            mosi_d = tx_q[FRAME_W-2];
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'(CS_HOLD)) begin
          cs_n_d  = 1'b1;
          ack_d   = 1'b1;
          dout_d  = cmd_q[WE_BIT] ? cmd_q :
                    {cmd_q[ADR_HI:ADR_LO], rx_q, 1'b0};
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        if (!bus.BUF_STATUS) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any frame in flight
  always_ff @(posedge WB_CLK_I) begin
    if (!WB_RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cmd_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: scoreboard bench
// two instances: (4,2,2) and (1,0,0)
module tb_spi_cmd_master;

  localparam int D0 = 4, S0 = 2, H0 = 2;
  localparam int D1 = 1, S1 = 0, H1 = 0;
  localparam int L0 = S0 + 82 * D0 + H0 + 1;
  localparam int L1 = S1 + 82 * D1 + H1 + 1;

  typedef struct {
    logic [40:0] resp;
    int          latch;
    int          lat;
  } exp_t;

  logic        clk = 0;
  logic [1:0]  rst_n = 2'b00;
  logic [1:0]  status = 2'b00;
  logic [1:0]  ack, busy, sclk, mosi, cs_n, miso;
  logic [40:0] din [2];
  logic [40:0] dout [2];

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat_of [2] = '{L0, L1};

  logic [40:0] mw [2] = '{41'h0, 41'h0};
  int          idx [2] = '{0, 0};
  int          nbits [2] = '{0, 0};
  int          stray [2] = '{0, 0};
  bit          abort [2] = '{0, 0};
  logic [40:0] cap [2];
  exp_t        rq [2][$];
  logic [40:0] fq [2][$];

  spi_cmd_master_if bif0 ();
  spi_cmd_master_if bif1 ();

  assign bif0.BUF_STATUS = status[0];
  assign bif0.BUF_DATA_I = din[0];
  assign bif1.BUF_STATUS = status[1];
  assign bif1.BUF_DATA_I = din[1];
  assign ack[0]  = bif0.BUF_ACK;
  assign ack[1]  = bif1.BUF_ACK;
  assign busy[0] = bif0.BUSY;
  assign busy[1] = bif1.BUSY;
  assign dout[0] = bif0.BUF_DATA_O;
  assign dout[1] = bif1.BUF_DATA_O;

  spi_cmd_master #(
    .CLK_DIV(D0), .CS_SETUP(S0), .CS_HOLD(H0)
  ) dut0 (
    .WB_CLK_I(clk),
    .WB_RST_I(rst_n[0]),
    .bus     (bif0),
    .SPI_SCLK(sclk[0]),
    .SPI_MOSI(mosi[0]),
    .SPI_MISO(miso[0]),
    .SPI_CS_N(cs_n[0])
  );

  spi_cmd_master #(
    .CLK_DIV(D1), .CS_SETUP(S1), .CS_HOLD(H1)
  ) dut1 (
    .WB_CLK_I(clk),
    .WB_RST_I(rst_n[1]),
    .bus     (bif1),
    .SPI_SCLK(sclk[1]),
    .SPI_MOSI(mosi[1]),
    .SPI_MISO(miso[1]),
    .SPI_CS_N(cs_n[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: MISO shows bit idx of the frame word
  always_comb begin
    miso = '0;
    for (int g = 0; g < 2; g++)
      miso[g] = (idx[g] < 41) ? mw[g][40 - idx[g]] : 1'b0;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: SPI frames and ACK responses vs queues
  initial begin
    logic [1:0]  p_sclk, p_cs, p_ack;
    logic [40:0] ef;
    exp_t        e;
    p_sclk = '0;
    p_cs   = '1;
    p_ack  = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (sclk[g] && !p_sclk[g]) begin
          if (cs_n[g]) stray[g]++;
          cap[g] = {cap[g][39:0], mosi[g]};
          nbits[g]++;
          idx[g]++;
        end
        if (!cs_n[g] && p_cs[g]) begin
          nbits[g] = 0;
          idx[g]   = 0;
        end
        if (cs_n[g] && !p_cs[g]) begin
          if (abort[g]) begin
            abort[g] = 0;
            if (fq[g].size() > 0) ef = fq[g].pop_front();
          end else if (fq[g].size() == 0) begin
            chk("frame_unexpected", 1, 0);
          end else begin
            ef = fq[g].pop_front();
            chk("frame_len", nbits[g], 41);
            chk("mosi_frame", cap[g], ef);
          end
          nbits[g] = 0;
          idx[g]   = 0;
        end
        if (ack[g] && !p_ack[g]) begin
          if (rq[g].size() == 0) begin
            chk("ack_unexpected", 1, 0);
          end else begin
            e = rq[g].pop_front();
            chk("resp_data", dout[g], e.resp);
            chk("ack_latency", cyc - e.latch, e.lat);
          end
        end
      end
      p_sclk = sclk;
      p_cs   = cs_n;
      p_ack  = ack;
    end
  end

  task automatic wait_idle(input int sel);
    int n = 0;
    while ((busy[sel] || ack[sel]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", {busy[sel], ack[sel]}, 0);
  endtask

  task automatic wait_ack(input int sel);
    int n = 0;
    while (!ack[sel] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", ack[sel], 1);
  endtask

  // issue one command; called on a negedge
  task automatic do_cmd(input int sel,
                        input logic we,
                        input logic [7:0] adr,
                        input logic [31:0] dat,
                        input logic [40:0] mwv,
                        input bit early,
                        input int hold);
    logic [40:0] cmd, resp;
    logic [63:0] r;
    exp_t        e;
    int          bad;
    wait_idle(sel);
    cmd  = {adr, dat, we};
    resp = we ? cmd : {adr, mwv[31:0], 1'b0};
    mw[sel] = mwv;
    fq[sel].push_back({we, adr, we ? dat : 32'h0});
    e.resp  = resp;
    e.latch = cyc + 1;
    e.lat   = lat_of[sel];
    rq[sel].push_back(e);
    status[sel] = 1'b1;
    din[sel]    = cmd;
    @(negedge clk);
    chk("busy_on", busy[sel], 1);
    r = {$urandom(), $urandom()};
    din[sel] = r[40:0];
    if (early) begin
      repeat (9) @(negedge clk);
      status[sel] = 1'b0;
    end
    wait_ack(sel);
    if (!early) begin
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!ack[sel] || !cs_n[sel] || sclk[sel]) bad++;
      end
      chk("ack_hold", bad, 0);
      status[sel] = 1'b0;
    end
    @(negedge clk);
    chk("ack_drop", ack[sel], 0);
    chk("busy_off", busy[sel], 0);
    chk("dout_hold", dout[sel], resp);
  endtask

  // reset instance 0 around bit 20 of a write
  task automatic reset_mid();
    int n = 0;
    wait_idle(0);
    mw[0] = '0;
    fq[0].push_back({1'b1, 8'h3C, 32'h0F0F1234});
    status[0] = 1'b1;
    din[0]    = {8'h3C, 32'h0F0F1234, 1'b1};
    while (nbits[0] < 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", nbits[0] >= 20, 1);
    abort[0]  = 1;
    rst_n[0]  = 1'b0;
    status[0] = 1'b0;
    @(negedge clk);
    chk("mid_cs_n", cs_n[0], 1);
    chk("mid_sclk", sclk[0], 0);
    chk("mid_mosi", mosi[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_ack", ack[0], 0);
    rst_n[0] = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_no_ack", ack[0], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [40:0] mv;
    int          sel;
    din[0] = '0;
    din[1] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ack", ack[g], 0);
      chk("rst_dout", dout[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_sclk", sclk[g], 0);
      chk("rst_mosi", mosi[g], 0);
      chk("rst_cs_n", cs_n[g], 1);
    end
    rst_n = 2'b11;
    @(negedge clk);

    r  = {$urandom(), $urandom()};
    mv = r[40:0];
    do_cmd(0, 1'b1, 8'h12, 32'hDEADBEEF, mv, 0, 0);
    do_cmd(0, 1'b0, 8'hA5, 32'h0,
           {mv[40:32], 32'hCAFEF00D}, 0, 50);
    reset_mid();
    do_cmd(0, 1'b1, 8'h5A, 32'h01234567, mv, 0, 2);
    do_cmd(0, 1'b1, 8'h77, 32'h89ABCDEF, mv, 1, 0);
    do_cmd(0, 1'b0, 8'h81, 32'hFFFFFFFF, ~mv, 1, 0);
    do_cmd(1, 1'b1, 8'hC3, 32'h13579BDF, mv, 0, 3);
    do_cmd(1, 1'b0, 8'h0F, 32'h0, ~mv, 0, 0);

    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 1));
      r   = {$urandom(), $urandom()};
      mv  = r[40:0];
      r   = {$urandom(), $urandom()};
      do_cmd(sel, r[0], r[15:8], r[63:32], mv,
             $urandom_range(0, 3) == 0,
             int'($urandom_range(0, 4)));
    end

    repeat (10) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("sclk_without_cs", stray[g], 0);
      chk("resp_queue_left", rq[g].size(), 0);
      chk("frame_queue_left", fq[g].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
